// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake with timeout/retry,
// holds the instruction register for the decoder and resolves branches on exec_done.
module instr_fetch #(
    parameter int unsigned         PC_W         = 8,
    parameter logic [PC_W-1:0]     RESET_VECTOR = '0,
    parameter int unsigned         TIMEOUT      = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [16:0]     imem_data,
    output logic [16:0]     instruction,
    output logic            instr_valid,
    input  logic            exec_done,
    input  logic [1:0]      BS,
    input  logic            PS,
    input  logic            zero,
    input  logic [PC_W-1:0] const_in,
    input  logic [PC_W-1:0] bus_a,
    output logic [PC_W-1:0] pc,
    output logic            fetch_error
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StRetry, StExec} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [16:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   next_pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_VECTOR;
            instr_q <= 17'h00000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // BS=01 and BS=11 are both conditional relative branches.
    always_comb begin
        next_pc = pc_q + PC_W'(1);
        unique case (BS)
            2'b00: next_pc = pc_q + PC_W'(1);
            2'b10: next_pc = bus_a;
            default: begin
                if (zero ^ PS) next_pc = pc_q + const_in;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        imem_req = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                imem_req = 1'b1;
                // An ack in the expiry cycle still wins over the timeout.
                if (imem_ack) begin
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StExec;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StRetry;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRetry: begin
                cnt_d   = '0;
                state_d = StFetch;
            end
            StExec: begin
                if (exec_done) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign fetch_error = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, branches, wrap, timeout/retry and reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [16:0] imem_data;
    logic [16:0] instruction;
    logic        instr_valid;
    logic        exec_done;
    logic [1:0]  BS;
    logic        PS;
    logic        zero;
    logic [7:0]  const_in;
    logic [7:0]  bus_a;
    logic [7:0]  pc;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.PC_W(8), .RESET_VECTOR(8'h00), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .BS          (BS),
        .PS          (PS),
        .zero        (zero),
        .const_in    (const_in),
        .bus_a       (bus_a),
        .pc          (pc),
        .fetch_error (fetch_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in a FETCH cycle at addr; acks at once, runs EXEC and resolves the branch.
    task automatic fetch_exec(input logic [7:0] addr, input logic [1:0] bs, input logic ps,
                              input logic z, input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] nxt);
        logic [16:0] word;
        word = 17'h10000 | {9'd0, addr};
        chk("fetch_req", {31'd0, imem_req}, 1);
        chk("fetch_addr", {24'd0, imem_addr}, {24'd0, addr});
        chk("fetch_valid", {31'd0, instr_valid}, 0);
        imem_ack  = 1'b1;
        imem_data = word;
        step();
        imem_ack  = 1'b0;
        imem_data = 17'h1FFFF;
        chk("exec_valid", {31'd0, instr_valid}, 1);
        chk("exec_instr", {15'd0, instruction}, {15'd0, word});
        chk("exec_req", {31'd0, imem_req}, 0);
        imem_ack  = 1'b1;
        imem_data = 17'h0AAAA;
        step();
        imem_ack = 1'b0;
        chk("exec_hold", {15'd0, instruction}, {15'd0, word});
        chk("exec_pc", {24'd0, pc}, {24'd0, addr});
        BS = bs; PS = ps; zero = z; const_in = c; bus_a = a;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        chk("next_pc", {24'd0, pc}, {24'd0, nxt});
    endtask

    initial begin
        reset_n = 1'b0; imem_ack = 1'b0; imem_data = '0; exec_done = 1'b0;
        BS = 2'b00; PS = 1'b0; zero = 1'b0; const_in = '0; bus_a = '0;
        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_instr", {15'd0, instruction}, 0);
        chk("rst_pc", {24'd0, pc}, 0);
        chk("rst_err", {31'd0, fetch_error}, 0);
        reset_n = 1'b1;
        step();

        fetch_exec(8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01);
        fetch_exec(8'h01, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02);
        fetch_exec(8'h02, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03);
        fetch_exec(8'h03, 2'b10, 1'b0, 1'b0, 8'h00, 8'h10, 8'h10);
        fetch_exec(8'h10, 2'b01, 1'b0, 1'b1, 8'hFC, 8'h00, 8'h0C);
        fetch_exec(8'h0C, 2'b10, 1'b0, 1'b0, 8'h00, 8'h10, 8'h10);
        fetch_exec(8'h10, 2'b01, 1'b0, 1'b0, 8'hFC, 8'h00, 8'h11);
        fetch_exec(8'h11, 2'b10, 1'b0, 1'b0, 8'h00, 8'h20, 8'h20);
        fetch_exec(8'h20, 2'b11, 1'b1, 1'b0, 8'h05, 8'h00, 8'h25);
        fetch_exec(8'h25, 2'b10, 1'b0, 1'b0, 8'h00, 8'h20, 8'h20);
        fetch_exec(8'h20, 2'b11, 1'b1, 1'b1, 8'h05, 8'h00, 8'h21);
        fetch_exec(8'h21, 2'b10, 1'b0, 1'b0, 8'h00, 8'h7E, 8'h7E);
        fetch_exec(8'h7E, 2'b10, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF);
        fetch_exec(8'hFF, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        fetch_exec(8'h00, 2'b10, 1'b0, 1'b0, 8'h00, 8'h02, 8'h02);
        fetch_exec(8'h02, 2'b01, 1'b0, 1'b1, 8'hFC, 8'h00, 8'hFE);

        // Timeout: 16 FETCH cycles without ack; stray exec_done must be ignored.
        exec_done = 1'b1; BS = 2'b10; bus_a = 8'h55;
        for (int i = 0; i < 15; i++) step();
        chk("to_req_last", {31'd0, imem_req}, 1);
        chk("to_err_before", {31'd0, fetch_error}, 0);
        step();
        exec_done = 1'b0;
        chk("retry_req", {31'd0, imem_req}, 0);
        chk("retry_err", {31'd0, fetch_error}, 1);
        chk("retry_pc", {24'd0, pc}, 8'hFE);
        step();
        chk("refetch_req", {31'd0, imem_req}, 1);
        chk("refetch_addr", {24'd0, imem_addr}, 8'hFE);
        step();
        step();
        imem_ack = 1'b1; imem_data = 17'h100FE;
        step();
        imem_ack = 1'b0;
        chk("retry_instr", {15'd0, instruction}, 17'h100FE);
        chk("retry_valid", {31'd0, instr_valid}, 1);
        chk("err_sticky", {31'd0, fetch_error}, 1);
        BS = 2'b00; exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        chk("after_retry_pc", {24'd0, pc}, 8'hFF);

        // Reset mid-fetch with a late ack.
        step();
        reset_n = 1'b0;
        step();
        chk("mid_rst_req", {31'd0, imem_req}, 0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 0);
        chk("mid_rst_instr", {15'd0, instruction}, 0);
        chk("mid_rst_pc", {24'd0, pc}, 0);
        chk("mid_rst_err", {31'd0, fetch_error}, 0);
        reset_n = 1'b1; imem_ack = 1'b1; imem_data = 17'h1ABCD;
        step();
        imem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, instr_valid}, 0);
        chk("late_ack_instr", {15'd0, instruction}, 0);
        chk("late_ack_req", {31'd0, imem_req}, 1);

        // Ack arriving in the timeout-expiry cycle wins.
        for (int i = 0; i < 15; i++) step();
        imem_ack = 1'b1; imem_data = 17'h12345;
        step();
        imem_ack = 1'b0;
        chk("edge_ack_valid", {31'd0, instr_valid}, 1);
        chk("edge_ack_instr", {15'd0, instruction}, 17'h12345);
        chk("edge_ack_err", {31'd0, fetch_error}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues requests to instruction memory over a req/ack handshake.
- Holds the 17-bit instruction register that drives the decoder's `instruction` input.
- Computes the next PC from the decoder/datapath branch controls (BS, PS) and the zero flag once the datapath signals the instruction is done.

Parameters:
- PC_W, 8, program counter / instruction address width.
- RESET_VECTOR, 0, PC value loaded on reset.
- TIMEOUT, 16, cycles to wait for imem_ack before retrying (minimum 2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_W  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory has imem_data valid this cycle.
- imem_data  in  17  fetched instruction word.
- instruction  out  17  instruction register, to the decoder.
- instr_valid  out  1  instruction register holds an instruction awaiting execution.
- exec_done  in  1  datapath finished the current instruction; BS/PS/zero/const_in/bus_a are valid this cycle.
- BS  in  2  branch select from the decoder.
- PS  in  1  branch polarity from the decoder.
- zero  in  1  ALU zero flag.
- const_in  in  PC_W  sign-extended relative branch offset.
- bus_a  in  PC_W  register A value, used as the absolute jump target.
- pc  out  PC_W  current program counter.
- fetch_error  out  1  sticky flag: at least one fetch timed out.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, pc=RESET_VECTOR, imem_req=0, instruction=17'h00000 (NOP), instr_valid=0, fetch_error=0, timeout counter=0.
  - Reset mid-fetch: imem_req drops at that edge; any later ack is ignored until a new request.
- States:
  - IDLE: imem_req=0. Unconditionally go to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc, counter increments each cycle.
    - On imem_ack=1: instruction<=imem_data, instr_valid<=1, imem_req<=0, counter<=0, go to EXEC.
    - If counter reaches TIMEOUT-1 with no ack: fetch_error<=1, go to RETRY.
  - RETRY: imem_req=0 for exactly one cycle, counter<=0, then FETCH at the same pc.
  - EXEC: imem_req=0, instruction held stable, instr_valid=1.
    - On exec_done=1: pc<=next_pc, instr_valid<=0, go to FETCH.
- Latency:
  - Zero-wait memory (ack in the first FETCH cycle): instruction is valid the cycle after the request.
  - Minimum instruction period: 2 cycles (FETCH + EXEC).
- next_pc, evaluated in the exec_done cycle:
  - BS=00: pc+1.
  - BS=01 or 11: if (zero XOR PS)=1, pc+const_in; else pc+1. This gives BIZ: PS=0, taken when zero=1; BNZ: PS=1, taken when zero=0.
  - BS=10: bus_a (absolute jump).
- Arithmetic is modulo 2^PC_W. pc = 2^PC_W-1 followed by +1 wraps to 0. Negative const_in wraps below 0.
- Ignored inputs:
  - exec_done outside EXEC.
  - imem_ack outside FETCH.
  - imem_data when imem_ack=0.
- imem_ack on the same cycle the timeout expires: the ack wins; no error, go to EXEC.
- fetch_error clears only on reset.
- instruction changes only on an accepted ack or on reset.

Test Plan:
- Reset, then ack every request in its first FETCH cycle with data = 17'h10000 | addr, pulse exec_done each EXEC, BS=00 -> imem_addr sequence 0,1,2,3; instruction 17'h10000,17'h10001,...; instr_valid alternating 1/0; fetch_error=0.
- pc=8'h10, BS=01, PS=0, zero=1, const_in=8'hFC -> next imem_addr=8'h0C. Repeat with zero=0 -> 8'h11.
- pc=8'h20, BS=11, PS=1, zero=0, const_in=8'h05 -> 8'h25. Repeat with zero=1 -> 8'h21. Then BS=10, bus_a=8'h7E -> 8'h7E.
- pc=8'hFF, BS=00 -> imem_addr=8'h00. pc=8'h02, BS=01, PS=0, zero=1, const_in=8'hFC -> 8'hFE.
- Withhold imem_ack for 16 cycles -> fetch_error=1, imem_req low one cycle, re-request same address. Ack on the 3rd cycle -> instruction latched, fetch_error stays 1.
- Assert reset_n=0 during FETCH with a late ack -> next edge: imem_req=0, instr_valid=0, instruction=0, pc=RESET_VECTOR; late ack ignored.
